// File: rtl/imem_load_controller.sv
// Loads a word stream into the low/high 16-entry instruction register banks and stalls the CPU meanwhile.
// Optional trailing checksum word is enabled by defining IMEM_LOAD_CHECKSUM_EN.
module imem_load_controller #(
  parameter int MAX_WORDS = 32
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic [5:0]  LENGTH,
  input  logic        ABORT,
  input  logic [15:0] WORD_IN,
  input  logic        WORD_VALID,
  output logic        WORD_READY,
  output logic [15:0] IMEM_DATA,
  output logic [3:0]  WRITE_SELECT,
  output logic        WRITE_ENABLE_LOW,
  output logic        WRITE_ENABLE_HIGH,
  output logic        CPU_HOLD,
  output logic        LOAD_DONE,
  output logic        LOAD_ERROR,
  output logic [5:0]  WORD_COUNT
);
  localparam logic [5:0] MAX_LEN  = 6'(MAX_WORDS);
  localparam logic       HAS_HIGH = (MAX_WORDS > 16);

`ifdef IMEM_LOAD_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
`endif

  state_t      state, state_next;
  logic [5:0]  remaining;
  logic [5:0]  len_clamped;
  logic        start_ok;
  logic        accept;
  logic        hold_next;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic        sum_accept;
  logic [15:0] sum;
`endif

  assign len_clamped = (LENGTH > MAX_LEN) ? MAX_LEN : LENGTH;

  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    accept     = 1'b0;
    WORD_READY = 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
    sum_accept = 1'b0;
`endif
    case (state)
      S_IDLE, S_DONE: begin
        if (START) begin
          start_ok   = 1'b1;
          state_next = (len_clamped == 6'd0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        WORD_READY = ~ABORT;
        if (ABORT) begin
          state_next = S_IDLE;
        end else if (WORD_VALID) begin
          accept = 1'b1;
          if (remaining == 6'd1) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
            state_next = S_CHECK;
`else
            state_next = S_DONE;
`endif
          end
        end
      end
`ifdef IMEM_LOAD_CHECKSUM_EN
      S_CHECK: begin
        WORD_READY = ~ABORT;
        if (ABORT) begin
          state_next = S_IDLE;
        end else if (WORD_VALID) begin
          sum_accept = 1'b1;
          state_next = S_DONE;
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase

    // Hold covers the whole load plus the cycle carrying the last write (or checksum) result.
    hold_next = (state_next == S_LOAD) | accept;
`ifdef IMEM_LOAD_CHECKSUM_EN
    hold_next = hold_next | (state_next == S_CHECK) | sum_accept;
`endif
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state             <= S_IDLE;
      remaining         <= 6'd0;
      WORD_COUNT        <= 6'd0;
      IMEM_DATA         <= 16'd0;
      WRITE_SELECT      <= 4'd0;
      WRITE_ENABLE_LOW  <= 1'b0;
      WRITE_ENABLE_HIGH <= 1'b0;
      CPU_HOLD          <= 1'b0;
      LOAD_DONE         <= 1'b0;
    end else begin
      state             <= state_next;
      WRITE_ENABLE_LOW  <= accept & ~WORD_COUNT[4];
      WRITE_ENABLE_HIGH <= accept & WORD_COUNT[4] & HAS_HIGH;
      CPU_HOLD          <= hold_next;
      LOAD_DONE         <= (state_next == S_DONE);
      if (start_ok) begin
        remaining  <= len_clamped;
        WORD_COUNT <= 6'd0;
      end
      if (accept) begin
        IMEM_DATA    <= WORD_IN;
        WRITE_SELECT <= WORD_COUNT[3:0];
        WORD_COUNT   <= WORD_COUNT + 6'd1;
        remaining    <= remaining - 6'd1;
      end
    end
  end

`ifdef IMEM_LOAD_CHECKSUM_EN
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      sum        <= 16'd0;
      LOAD_ERROR <= 1'b0;
    end else begin
      if (start_ok) begin
        sum        <= 16'd0;
        LOAD_ERROR <= 1'b0;
      end
      if (accept) sum <= sum + WORD_IN;
      if (sum_accept) LOAD_ERROR <= (sum != WORD_IN);
    end
  end
`else
  assign LOAD_ERROR = 1'b0;
`endif

endmodule

// File: doc/imem_load_controller.md
# imem_load_controller

Sequencing controller that fills the two 16-word read-only instruction register file banks (low and high) from an external word stream, e.g. a UART or switch-panel loader. It accepts words on a valid/ready handshake, maps each word index to bank/entry, drives the register files' write select, write enables and data, and holds the CPU while a load is in progress. It sits between the loader front-end and the instruction memory banks, alongside the CPU's fetch path.

## Interface

Parameters:
- MAX_WORDS, 32, capacity in words; legal values 16 (low bank only) or 32 (low then high)

Ports:
- CLOCK  in  1  system clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- START  in  1  one-cycle pulse; begins a load, samples LENGTH
- LENGTH  in  6  words to load; 0 = no writes; values above MAX_WORDS are clamped to MAX_WORDS
- ABORT  in  1  cancels the active load
- WORD_IN  in  16  incoming instruction word
- WORD_VALID  in  1  WORD_IN valid
- WORD_READY  out  1  controller accepts WORD_IN this cycle
- IMEM_DATA  out  16  write data to both banks
- WRITE_SELECT  out  4  entry index within the bank
- WRITE_ENABLE_LOW  out  1  write strobe, low bank
- WRITE_ENABLE_HIGH  out  1  write strobe, high bank
- CPU_HOLD  out  1  stall request to the CPU
- LOAD_DONE  out  1  last load completed successfully
- LOAD_ERROR  out  1  checksum mismatch (see Configuration)
- WORD_COUNT  out  6  words accepted in the current/last load

## Operation

- FSM states: IDLE, LOAD, CHECK, DONE.
- IDLE/DONE + START: latch clamped LENGTH into `remaining`, clear WORD_COUNT, LOAD_DONE, LOAD_ERROR and the checksum. Go to LOAD, or to DONE directly when LENGTH = 0. START in LOAD or CHECK is ignored.
- LOAD: WORD_READY = ~ABORT. A transfer occurs when WORD_VALID & WORD_READY.
  - Each transfer registers WORD_IN into IMEM_DATA and index k = WORD_COUNT into WRITE_SELECT = k[3:0].
  - The next cycle asserts WRITE_ENABLE_LOW when k[4] = 0, or WRITE_ENABLE_HIGH when k[4] = 1.
  - WORD_COUNT increments on each transfer.
  - On the transfer that completes LENGTH words, go to CHECK when checksum is enabled, otherwise to DONE.
- CHECK: WORD_READY = ~ABORT. The next transfer is the checksum word. It is not written to memory. Set LOAD_ERROR = (sum != word), then go to DONE.
- DONE: LOAD_DONE = 1, held until the next START.
- ABORT in LOAD or CHECK:
  - Nothing is accepted that cycle.
  - A write already registered from the prior cycle still completes.
  - Go to IDLE. LOAD_DONE stays 0 and WORD_COUNT holds its value.
- The write strobes are mutually exclusive and are never asserted outside the cycle after a transfer.
- With MAX_WORDS = 16, WRITE_ENABLE_HIGH is constant 0.

## Timing

- Reset values:
  - State = IDLE.
  - WORD_READY, WRITE_ENABLE_LOW, WRITE_ENABLE_HIGH, CPU_HOLD, LOAD_DONE and LOAD_ERROR are all 0.
  - IMEM_DATA = 0, WRITE_SELECT = 0, WORD_COUNT = 0.
- START at cycle N gives state LOAD and WORD_READY = 1 at N+1.
- Write latency: a transfer at cycle T produces the write strobe, data and select at T+1. Throughput is one word per cycle.
- CPU_HOLD is registered:
  - It is 1 from the cycle after START through the cycle carrying the final write strobe.
  - For a load that ends in CHECK, it is 1 through the cycle after the checksum transfer.
  - It is 0 the following cycle.
- LOAD_DONE rises in the cycle after the final transfer, which is the same cycle as the last write strobe.
- An asynchronous reset mid-load forces all outputs to their reset values immediately. Partially written entries keep their contents.

## Configuration

- IMEM_LOAD_CHECKSUM_EN defined:
  - A 16-bit wrap-around sum of the accepted data words is kept.
  - The CHECK state exists.
  - LOAD_ERROR reports a mismatch.
  - LOAD_DONE is asserted even on mismatch.
- IMEM_LOAD_CHECKSUM_EN undefined:
  - There is no CHECK state and no sum register.
  - LOAD_ERROR is tied to 0.
  - LOAD goes to DONE directly.

## Test plan

- Reset, then START with LENGTH = 3 and continuous valid words 0xA001, 0xA002, 0xA003:
  - WRITE_ENABLE_LOW is asserted in three consecutive cycles with WRITE_SELECT 0, 1, 2.
  - WORD_COUNT = 3 and LOAD_DONE = 1.
  - CPU_HOLD falls after the third write.
- LENGTH = 40, MAX_WORDS = 32:
  - The length is clamped to 32.
  - Words 0–15 go to the low bank and words 16–31 go to the high bank, both with select 0..15.
  - WORD_READY is 0 after the 32nd transfer.
- WORD_VALID toggled every other cycle with LENGTH = 4: exactly 4 writes occur, each one cycle after its transfer, with no duplicate or missing index.
- ABORT asserted while WORD_VALID = 1 after 2 words:
  - The third word is not accepted and only 2 writes occur.
  - State returns to IDLE with LOAD_DONE = 0 and WORD_COUNT = 2.
- With IMEM_LOAD_CHECKSUM_EN, LENGTH = 2, words 0x8000 and 0x8001:
  - A checksum word of 0x0001 gives LOAD_ERROR = 0.
  - Repeating with 0x0002 gives LOAD_ERROR = 1.
  - The checksum word is never written.
- START with LENGTH = 0: DONE is reached at N+1 with no write strobes. A START issued during LOAD is ignored.
